// File: rtl/axi_vdma_pkg.sv
// ---------------------------------------------------------------------------
// axi_vdma_pkg
// Purpose : shared types and AXI constants for the VDMA state cores.
// Contents: state_e    - burst sequencer states (IDLE, ADDR, DATA, DONE)
//           BURST_INCR - ARBURST/AWBURST encoding for incrementing bursts
//           CACHE_DEF  - default ARCACHE/AWCACHE (bufferable, modifiable)
//           RESP_OKAY  - RRESP/BRESP encoding for a clean transfer
//           clog2()    - ceiling log2, used to derive ARSIZE from DSIZE
// ---------------------------------------------------------------------------
package axi_vdma_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] CACHE_DEF  = 4'b0011;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Smallest n with 2**n >= value; value 1 gives 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/axi_inf_read_state_core_if.sv
// ---------------------------------------------------------------------------
// axi_inf_read_state_core_if
// Purpose : AXI4 read-address and read-data channel bundle.
// Modports: master - drives AR fields, ARVALID and RREADY; samples ARREADY
//                    and the R channel
//           slave  - the memory side, mirror image of master
// Params  : IDSIZE (ID width), LSIZE (ARLEN width), ASIZE (address width),
//           DSIZE (data width)
// ---------------------------------------------------------------------------
interface axi_inf_read_state_core_if #(
   parameter int IDSIZE = 3,
   parameter int LSIZE  = 9,
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 256
);

   logic [IDSIZE-1:0] axi_arid;
   logic [ASIZE-1:0]  axi_araddr;
   logic [LSIZE-1:0]  axi_arlen;
   logic [2:0]        axi_arsize;
   logic [1:0]        axi_arburst;
   logic              axi_arlock;
   logic [3:0]        axi_arcache;
   logic [2:0]        axi_arprot;
   logic [3:0]        axi_arqos;
   logic              axi_arvalid;
   logic              axi_arready;

   logic [IDSIZE-1:0] axi_rid;
   logic [DSIZE-1:0]  axi_rdata;
   logic [1:0]        axi_rresp;
   logic              axi_rlast;
   logic              axi_rvalid;
   logic              axi_rready;

   modport master (
      output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
             axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
      input  axi_arready,
      input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      output axi_rready
   );

   modport slave (
      input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
             axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
      output axi_arready,
      output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      input  axi_rready
   );

endinterface

// File: rtl/axi_inf_read_state_core.sv
// ---------------------------------------------------------------------------
// axi_inf_read_state_core
// Purpose : single-outstanding AXI4 read-burst master. Takes one burst request
//           (address + beats-1), issues AR, accepts the R beats and pushes each
//           one into the downstream stream FIFO, throttling RREADY on FIFO
//           almost-full.
// Ports   : axi_aclk, axi_resetn          - clock, async active-low reset
//           read_req, req_len, req_addr   - burst request (sampled in IDLE)
//           req_resp                      - pulse after the AR handshake
//           req_done                      - pulse after the last beat is pushed
//           fifo_almost_full              - downstream backpressure
//           push_data_en/push_data/push_last - FIFO write port (registered)
//           rd_err                        - sticky read-error flag (optional)
//           axi                           - AR/R channels, master modport
// Options : READ_RESP_CHECK_EN - when defined, adds rd_err, which latches any
//           non-OKAY RRESP, wrong RID, or RLAST out of place on an accepted beat.
// ---------------------------------------------------------------------------
module axi_inf_read_state_core
   import axi_vdma_pkg::*;
#(
   parameter int IDSIZE = 3,
   parameter int ID     = 0,
   parameter int LSIZE  = 9,
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 256
) (
   input  logic              axi_aclk,
   input  logic              axi_resetn,
   input  logic              read_req,
   input  logic [LSIZE-1:0]  req_len,
   input  logic [ASIZE-1:0]  req_addr,
   output logic              req_resp,
   output logic              req_done,
   input  logic              fifo_almost_full,
   output logic              push_data_en,
   output logic [DSIZE-1:0]  push_data,
   output logic              push_last,
`ifdef READ_RESP_CHECK_EN
   output logic              rd_err,
`endif
   axi_inf_read_state_core_if.master axi
);

   localparam int                ARSIZE_I = clog2(DSIZE / 8);
   localparam logic [2:0]        ARSIZE_C = ARSIZE_I[2:0];
   localparam logic [IDSIZE-1:0] ID_C     = IDSIZE'(ID);

   state_e             state_q,     state_d;
   logic [ASIZE-1:0]   araddr_q,    araddr_d;
   logic [LSIZE-1:0]   arlen_q,     arlen_d;
   logic               arvalid_q,   arvalid_d;
   logic               req_resp_q,  req_resp_d;
   logic               req_done_q,  req_done_d;
   logic [LSIZE-1:0]   cnt_q,       cnt_d;
   logic               push_en_q,   push_en_d;
   logic [DSIZE-1:0]   push_data_q, push_data_d;
   logic               push_last_q, push_last_d;

   logic               in_data;
   logic               beat_acc;
   logic               is_last;

   // RREADY only depends on the registered state and the FIFO flag, so it can
   // follow almost-full cycle by cycle without a combinational path from R.
   assign in_data  = (state_q == DATA);
   assign beat_acc = axi.axi_rvalid && axi.axi_rready;
   assign is_last  = (cnt_q == arlen_q);

   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      arvalid_d   = arvalid_q;
      req_resp_d  = 1'b0;
      req_done_d  = 1'b0;
      cnt_d       = cnt_q;
      push_en_d   = 1'b0;
      push_data_d = push_data_q;
      push_last_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (read_req) begin
               araddr_d  = req_addr;
               arlen_d   = req_len;
               arvalid_d = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (axi.axi_arready) begin
               arvalid_d  = 1'b0;
               req_resp_d = 1'b1;
               state_d    = DATA;
            end
         end
         DATA: begin
            // Termination is by beat count against ARLEN, never by RLAST; the
            // counter is not bumped on the final beat so ARLEN=max cannot wrap.
            if (beat_acc) begin
               push_en_d   = 1'b1;
               push_data_d = axi.axi_rdata;
               push_last_d = is_last;
               if (is_last) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + LSIZE'(1);
               end
            end
         end
         DONE: begin
            req_done_d = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q     <= IDLE;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arvalid_q   <= 1'b0;
         req_resp_q  <= 1'b0;
         req_done_q  <= 1'b0;
         cnt_q       <= '0;
         push_en_q   <= 1'b0;
         push_data_q <= '0;
         push_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         arvalid_q   <= arvalid_d;
         req_resp_q  <= req_resp_d;
         req_done_q  <= req_done_d;
         cnt_q       <= cnt_d;
         push_en_q   <= push_en_d;
         push_data_q <= push_data_d;
         push_last_q <= push_last_d;
      end
   end

`ifdef READ_RESP_CHECK_EN
   logic rd_err_q, rd_err_d;
   logic beat_bad;

   // RLAST must appear exactly on the beat the counter says is final.
   assign beat_bad = (axi.axi_rresp != RESP_OKAY) ||
                     (axi.axi_rid != ID_C) ||
                     (axi.axi_rlast != is_last);

   always_comb begin
      rd_err_d = rd_err_q;
      if (in_data && beat_acc && beat_bad) begin
         rd_err_d = 1'b1;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         rd_err_q <= 1'b0;
      end else begin
         rd_err_q <= rd_err_d;
      end
   end

   assign rd_err = rd_err_q;
`else
   logic unused_resp;
   assign unused_resp = ^{axi.axi_rid, axi.axi_rresp, axi.axi_rlast};
`endif

   assign req_resp     = req_resp_q;
   assign req_done     = req_done_q;
   assign push_data_en = push_en_q;
   assign push_data    = push_data_q;
   assign push_last    = push_last_q;

   assign axi.axi_arid    = ID_C;
   assign axi.axi_araddr  = araddr_q;
   assign axi.axi_arlen   = arlen_q;
   assign axi.axi_arsize  = ARSIZE_C;
   assign axi.axi_arburst = BURST_INCR;
   assign axi.axi_arlock  = 1'b0;
   assign axi.axi_arcache = CACHE_DEF;
   assign axi.axi_arprot  = 3'b000;
   assign axi.axi_arqos   = 4'b0000;
   assign axi.axi_arvalid = arvalid_q;
   assign axi.axi_rready  = in_data && !fifo_almost_full;

endmodule

// File: tb/tb_axi_inf_read_state_core.sv
// ---------------------------------------------------------------------------
// tb_axi_inf_read_state_core
// Purpose : self-checking bench for axi_inf_read_state_core. A memory-side
//           model answers AR with a pre-generated list of beats; the expected
//           FIFO stream is simply that list in order, last flag on the final
//           entry. A negedge monitor records pushes, pulses and handshakes.
// Options : READ_RESP_CHECK_EN enables the rd_err scenarios.
// ---------------------------------------------------------------------------
module tb_axi_inf_read_state_core;

   localparam int IDSIZE = 3;
   localparam int ID     = 0;
   localparam int LSIZE  = 9;
   localparam int ASIZE  = 32;
   localparam int DSIZE  = 256;

   logic              axi_aclk = 1'b0;
   logic              axi_resetn;
   logic              read_req;
   logic [LSIZE-1:0]  req_len;
   logic [ASIZE-1:0]  req_addr;
   logic              req_resp;
   logic              req_done;
   logic              fifo_almost_full;
   logic              push_data_en;
   logic [DSIZE-1:0]  push_data;
   logic              push_last;
`ifdef READ_RESP_CHECK_EN
   logic              rd_err;
`endif

   axi_inf_read_state_core_if #(
      .IDSIZE (IDSIZE), .LSIZE (LSIZE), .ASIZE (ASIZE), .DSIZE (DSIZE)
   ) axi ();

   axi_inf_read_state_core #(
      .IDSIZE (IDSIZE), .ID (ID), .LSIZE (LSIZE), .ASIZE (ASIZE), .DSIZE (DSIZE)
   ) dut (
      .axi_aclk         (axi_aclk),
      .axi_resetn       (axi_resetn),
      .read_req         (read_req),
      .req_len          (req_len),
      .req_addr         (req_addr),
      .req_resp         (req_resp),
      .req_done         (req_done),
      .fifo_almost_full (fifo_almost_full),
      .push_data_en     (push_data_en),
      .push_data        (push_data),
      .push_last        (push_last),
`ifdef READ_RESP_CHECK_EN
      .rd_err           (rd_err),
`endif
      .axi              (axi.master)
   );

   always #5 axi_aclk = ~axi_aclk;

   int n_cmp = 0;
   int n_bad = 0;

   // Observation state filled by the monitor.
   int               cyc = 0;
   logic [DSIZE-1:0] got_data[$];
   bit               got_last[$];
   int               resp_cnt, done_cnt, ar_hs_cnt, rhs_cnt;
   int               last_hs_cyc, done_cyc;

   // Per-burst results from the memory model.
   logic [DSIZE-1:0] exp_data[$];
   bit               lat_ok, ar_stable, timeout;
   int               rready_bad;
   logic [ASIZE-1:0] ar_addr_seen;
   logic [LSIZE-1:0] ar_len_seen;
   logic [2:0]       ar_size_seen;
   logic [1:0]       ar_burst_seen;

   always @(posedge axi_aclk) cyc <= cyc + 1;

   always @(negedge axi_aclk) begin
      if (push_data_en === 1'b1) begin
         got_data.push_back(push_data);
         got_last.push_back(push_last);
      end
      if (req_resp === 1'b1) resp_cnt++;
      if (req_done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (axi.axi_arvalid === 1'b1 && axi.axi_arready === 1'b1) ar_hs_cnt++;
      if (axi.axi_rvalid === 1'b1 && axi.axi_rready === 1'b1) begin
         rhs_cnt++;
         last_hs_cyc = cyc;
      end
   end

   function automatic logic [DSIZE-1:0] rand_word();
      logic [DSIZE-1:0] w;
      for (int i = 0; i < DSIZE / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [63:0] ar_snapshot();
      return 64'({axi.axi_arid, axi.axi_araddr, axi.axi_arlen, axi.axi_arsize,
                  axi.axi_arburst, axi.axi_arlock, axi.axi_arcache,
                  axi.axi_arprot, axi.axi_arqos});
   endfunction

   // Index of the first push that differs from the expected stream, -1 if none.
   function automatic int first_push_error();
      int n;
      n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         if (got_data[i] !== exp_data[i] || got_last[i] !== (i == exp_data.size() - 1))
            return i;
      end
      return -1;
   endfunction

   task automatic clear_obs();
      got_data.delete();
      got_last.delete();
      resp_cnt = 0; done_cnt = 0; ar_hs_cnt = 0; rhs_cnt = 0;
      last_hs_cyc = 0; done_cyc = 0;
   endtask

   // Memory-side model for one burst. Starts and ends at posedge+1.
   // af_mode: 0 never almost-full, 1 toggling each cycle, 2 random.
   task automatic applyStimulus(input logic [ASIZE-1:0] addr, input int len,
                                input int ar_delay, input int rv_pct,
                                input int af_mode, input bit poke_req,
                                input int bad_resp_idx, input int early_last_idx);
      int          idx, budget;
      bit          hs, tog;
      logic [63:0] snap;
      clear_obs();
      exp_data.delete();
      for (int i = 0; i <= len; i++) exp_data.push_back(rand_word());
      lat_ok = 0; ar_stable = 1; timeout = 0; rready_bad = 0; tog = 0;
      req_addr = addr;
      req_len  = LSIZE'(len);
      read_req = 1'b1;
      @(posedge axi_aclk); #1;
      read_req = 1'b0;
      lat_ok        = (axi.axi_arvalid === 1'b1);
      snap          = ar_snapshot();
      ar_addr_seen  = axi.axi_araddr;
      ar_len_seen   = axi.axi_arlen;
      ar_size_seen  = axi.axi_arsize;
      ar_burst_seen = axi.axi_arburst;
      for (int k = 0; k < ar_delay; k++) begin
         if (ar_snapshot() !== snap || axi.axi_arvalid !== 1'b1) ar_stable = 0;
         @(posedge axi_aclk); #1;
      end
      if (ar_snapshot() !== snap || axi.axi_arvalid !== 1'b1) ar_stable = 0;
      axi.axi_arready = 1'b1;
      @(posedge axi_aclk); #1;
      axi.axi_arready = 1'b0;
      idx    = 0;
      budget = (len + 1) * 30 + 50;
      while (idx <= len && budget > 0) begin
         read_req = poke_req;
         tog = ~tog;
         case (af_mode)
            1:       fifo_almost_full = tog;
            2:       fifo_almost_full = ($urandom_range(0, 2) == 0);
            default: fifo_almost_full = 1'b0;
         endcase
         axi.axi_rvalid = ($urandom_range(1, 100) <= rv_pct);
         axi.axi_rdata  = exp_data[idx];
         axi.axi_rid    = IDSIZE'(ID);
         axi.axi_rresp  = (idx == bad_resp_idx) ? 2'b10 : 2'b00;
         axi.axi_rlast  = (idx == len) || (idx == early_last_idx);
         #1;
         if (axi.axi_rready !== !fifo_almost_full) rready_bad++;
         hs = (axi.axi_rvalid === 1'b1) && (axi.axi_rready === 1'b1);
         @(posedge axi_aclk); #1;
         if (hs) idx++;
         budget--;
      end
      read_req = 1'b0;
      axi.axi_rvalid = 1'b0;
      axi.axi_rlast  = 1'b0;
      axi.axi_rresp  = 2'b00;
      fifo_almost_full = 1'b0;
      if (idx <= len) timeout = 1;
      for (int k = 0; k < 8 && done_cnt == 0; k++) begin
         @(posedge axi_aclk); #1;
      end
      @(posedge axi_aclk); #1;
   endtask

   task automatic test_reset();
      axi_resetn = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      n_cmp++;
      if ({axi.axi_arvalid, axi.axi_rready, push_data_en, push_last, req_resp, req_done} !== 6'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                  {axi.axi_arvalid, axi.axi_rready, push_data_en, push_last, req_resp, req_done});
      end
      n_cmp++;
      if ({axi.axi_araddr, axi.axi_arlen} !== '0 || push_data !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_data: araddr %0h arlen %0d push_data nonzero=%0b expected all 0",
                  axi.axi_araddr, axi.axi_arlen, |push_data);
      end
      n_cmp++;
      if ({axi.axi_arid, axi.axi_arsize, axi.axi_arburst, axi.axi_arlock, axi.axi_arcache,
           axi.axi_arprot, axi.axi_arqos} !== {3'd0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}) begin
         n_bad++;
         $display("[TB] FAIL reset_const: id %0d size %0d burst %0d lock %0d cache %0d prot %0d qos %0d expected 0 5 1 0 3 0 0",
                  axi.axi_arid, axi.axi_arsize, axi.axi_arburst, axi.axi_arlock,
                  axi.axi_arcache, axi.axi_arprot, axi.axi_arqos);
      end
      axi_resetn = 1'b1;
      @(posedge axi_aclk); #1;
   endtask

   task automatic test_basic();
      int e;
      applyStimulus(32'h1000, 7, 2, 100, 0, 0, -1, -1);
      n_cmp++;
      if (lat_ok !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_arvalid_latency: got %0b expected 1", lat_ok); end
      n_cmp++;
      if (ar_addr_seen !== 32'h1000) begin n_bad++; $display("[TB] FAIL basic_araddr: got %0h expected 1000", ar_addr_seen); end
      n_cmp++;
      if (ar_len_seen !== 9'd7) begin n_bad++; $display("[TB] FAIL basic_arlen: got %0d expected 7", ar_len_seen); end
      n_cmp++;
      if ({ar_size_seen, ar_burst_seen} !== {3'd5, 2'b01}) begin
         n_bad++; $display("[TB] FAIL basic_size_burst: got %0d/%0d expected 5/1", ar_size_seen, ar_burst_seen);
      end
      n_cmp++;
      if (got_data.size() !== 8) begin n_bad++; $display("[TB] FAIL basic_push_count: got %0d expected 8", got_data.size()); end
      e = first_push_error();
      n_cmp++;
      if (e !== -1) begin n_bad++; $display("[TB] FAIL basic_push_seq: first bad beat %0d expected none", e); end
      n_cmp++;
      if ({resp_cnt, done_cnt} !== {32'd1, 32'd1}) begin
         n_bad++; $display("[TB] FAIL basic_pulses: resp %0d done %0d expected 1 1", resp_cnt, done_cnt);
      end
   endtask

   task automatic test_len0_stall();
      int e;
      applyStimulus(32'hABCD_0040, 0, 10, 100, 0, 0, -1, -1);
      n_cmp++;
      if (ar_stable !== 1'b1) begin n_bad++; $display("[TB] FAIL len0_ar_stable: got %0b expected 1", ar_stable); end
      n_cmp++;
      if (got_data.size() !== 1) begin n_bad++; $display("[TB] FAIL len0_push_count: got %0d expected 1", got_data.size()); end
      e = first_push_error();
      n_cmp++;
      if (e !== -1) begin n_bad++; $display("[TB] FAIL len0_push_seq: first bad beat %0d expected none", e); end
      n_cmp++;
      if (done_cnt !== 1 || (done_cyc - last_hs_cyc) !== 2) begin
         n_bad++; $display("[TB] FAIL len0_done_timing: done %0d delay %0d expected 1 and 2", done_cnt, done_cyc - last_hs_cyc);
      end
   endtask

   task automatic test_backpressure();
      int e;
      applyStimulus(32'h0002_0000, 15, 0, 100, 1, 0, -1, -1);
      n_cmp++;
      if (rready_bad !== 0) begin n_bad++; $display("[TB] FAIL bp_rready_mirror: got %0d bad cycles expected 0", rready_bad); end
      n_cmp++;
      if (got_data.size() !== 16 || timeout) begin
         n_bad++; $display("[TB] FAIL bp_push_count: got %0d timeout %0b expected 16 0", got_data.size(), timeout);
      end
      e = first_push_error();
      n_cmp++;
      if (e !== -1) begin n_bad++; $display("[TB] FAIL bp_push_seq: first bad beat %0d expected none", e); end
   endtask

   task automatic test_second_req();
      int e;
      applyStimulus(32'h0000_3000, 5, 1, 70, 0, 1, -1, -1);
      repeat (3) @(posedge axi_aclk);
      #1;
      n_cmp++;
      if ({ar_hs_cnt, resp_cnt, done_cnt} !== {32'd1, 32'd1, 32'd1}) begin
         n_bad++; $display("[TB] FAIL second_req_single_ar: ar %0d resp %0d done %0d expected 1 1 1",
                           ar_hs_cnt, resp_cnt, done_cnt);
      end
      n_cmp++;
      if (axi.axi_arvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL second_req_idle: arvalid %0b expected 0", axi.axi_arvalid); end
      e = first_push_error();
      n_cmp++;
      if (e !== -1 || got_data.size() !== 6) begin
         n_bad++; $display("[TB] FAIL second_req_push: bad beat %0d count %0d expected -1 6", e, got_data.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      int e, guard;
      clear_obs();
      req_addr = 32'h0000_8000;
      req_len  = 9'd7;
      read_req = 1'b1;
      @(posedge axi_aclk); #1;
      read_req = 1'b0;
      axi.axi_arready = 1'b1;
      @(posedge axi_aclk); #1;
      axi.axi_arready = 1'b0;
      axi.axi_rvalid  = 1'b1;
      axi.axi_rresp   = 2'b00;
      axi.axi_rid     = IDSIZE'(ID);
      guard = 0;
      while (got_data.size() < 3 && guard < 30) begin
         axi.axi_rdata = rand_word();
         @(posedge axi_aclk); #1;
         guard++;
      end
      n_cmp++;
      if (got_data.size() !== 3) begin n_bad++; $display("[TB] FAIL abort_reach_beat3: got %0d expected 3", got_data.size()); end
      #2;
      axi_resetn = 1'b0;
      #1;
      n_cmp++;
      if ({axi.axi_arvalid, axi.axi_rready, push_data_en, push_last, req_resp, req_done} !== 6'b0 ||
          push_data !== '0) begin
         n_bad++; $display("[TB] FAIL abort_async_clear: ctrl %b data nonzero=%0b expected 000000 0",
                           {axi.axi_arvalid, axi.axi_rready, push_data_en, push_last, req_resp, req_done}, |push_data);
      end
      axi.axi_rvalid = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      axi_resetn = 1'b1;
      repeat (3) @(posedge axi_aclk);
      #1;
      n_cmp++;
      if (done_cnt !== 0) begin n_bad++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); end
      applyStimulus(32'h0000_9000, 7, 0, 100, 0, 0, -1, -1);
      e = first_push_error();
      n_cmp++;
      if (e !== -1 || got_data.size() !== 8 || done_cnt !== 1) begin
         n_bad++; $display("[TB] FAIL abort_recover: bad beat %0d count %0d done %0d expected -1 8 1",
                           e, got_data.size(), done_cnt);
      end
   endtask

   task automatic test_random();
      int e, len;
      logic [ASIZE-1:0] addr;
      for (int it = 0; it < 6; it++) begin
         len  = $urandom_range(0, 40);
         addr = {$urandom, 5'b0};
         applyStimulus(addr, len, $urandom_range(0, 4), $urandom_range(30, 100), 2, 0, -1, -1);
         e = first_push_error();
         n_cmp++;
         if (e !== -1 || got_data.size() !== len + 1 || timeout) begin
            n_bad++; $display("[TB] FAIL random_%0d_push: bad beat %0d count %0d timeout %0b expected -1 %0d 0",
                              it, e, got_data.size(), timeout, len + 1);
         end
         n_cmp++;
         if (ar_addr_seen !== addr || ar_len_seen !== LSIZE'(len) || rready_bad !== 0) begin
            n_bad++; $display("[TB] FAIL random_%0d_ar: addr %0h len %0d rready_bad %0d expected %0h %0d 0",
                              it, ar_addr_seen, ar_len_seen, rready_bad, addr, len);
         end
      end
   endtask

   task automatic test_max_len();
      int e;
      applyStimulus(32'h4000_0000, 511, 0, 100, 0, 0, -1, -1);
      e = first_push_error();
      n_cmp++;
      if (e !== -1 || got_data.size() !== 512 || done_cnt !== 1) begin
         n_bad++; $display("[TB] FAIL maxlen_push: bad beat %0d count %0d done %0d expected -1 512 1",
                           e, got_data.size(), done_cnt);
      end
   endtask

`ifdef READ_RESP_CHECK_EN
   task automatic test_rd_err();
      n_cmp++;
      if (rd_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rderr_clean: got %0b expected 0", rd_err); end
      applyStimulus(32'h0000_5000, 7, 0, 100, 0, 0, 1, -1);
      n_cmp++;
      if (rd_err !== 1'b1 || got_data.size() !== 8) begin
         n_bad++; $display("[TB] FAIL rderr_rresp: rd_err %0b count %0d expected 1 8", rd_err, got_data.size());
      end
      applyStimulus(32'h0000_6000, 3, 0, 100, 0, 0, -1, -1);
      n_cmp++;
      if (rd_err !== 1'b1) begin n_bad++; $display("[TB] FAIL rderr_sticky: got %0b expected 1", rd_err); end
      axi_resetn = 1'b0;
      @(posedge axi_aclk); #1;
      axi_resetn = 1'b1;
      @(posedge axi_aclk); #1;
      n_cmp++;
      if (rd_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rderr_reset: got %0b expected 0", rd_err); end
      applyStimulus(32'h0000_7000, 7, 0, 100, 0, 0, -1, 3);
      n_cmp++;
      if (rd_err !== 1'b1 || got_data.size() !== 8 || first_push_error() !== -1) begin
         n_bad++; $display("[TB] FAIL rderr_early_last: rd_err %0b count %0d expected 1 8", rd_err, got_data.size());
      end
   endtask
`endif

   initial begin
      axi_resetn       = 1'b0;
      read_req         = 1'b0;
      req_len          = '0;
      req_addr         = '0;
      fifo_almost_full = 1'b0;
      axi.axi_arready  = 1'b0;
      axi.axi_rid      = '0;
      axi.axi_rdata    = '0;
      axi.axi_rresp    = 2'b00;
      axi.axi_rlast    = 1'b0;
      axi.axi_rvalid   = 1'b0;
      clear_obs();
      #1;
      test_reset();
      test_basic();
      test_len0_stall();
      test_backpressure();
      test_second_req();
      test_reset_mid_burst();
      test_random();
      test_max_len();
`ifdef READ_RESP_CHECK_EN
      test_rd_err();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_inf_read_state_core.md
Name: axi_inf_read_state_core

Overview:
- Single-outstanding AXI4 read-burst master; the read-side counterpart of the write state core in the VDMA.
- Accepts one burst request (address + length) from the read-address generator.
- Drives AR, accepts R beats, and pushes each data beat into the downstream stream FIFO.
- Throttles RREADY on FIFO almost-full so no beat is ever dropped.

Parameters:
- IDSIZE, 3, width of ARID/RID.
- ID, 0, constant value driven on ARID.
- LSIZE, 9, width of req_len/ARLEN; beats = value+1.
- ASIZE, 32, address width.
- DSIZE, 256, data width; ARSIZE = log2(DSIZE/8).

Ports:
- axi_aclk, in, 1, sole clock.
- axi_resetn, in, 1, asynchronous active-low reset.
- read_req, in, 1, level request, sampled only in IDLE.
- req_len, in, LSIZE, beats-1; captured with read_req.
- req_addr, in, ASIZE, byte start address; captured with read_req.
- req_resp, out, 1, one-cycle pulse on AR handshake.
- req_done, out, 1, one-cycle pulse after the last beat is pushed.
- fifo_almost_full, in, 1, downstream backpressure.
- push_data_en, out, 1, FIFO write enable.
- push_data, out, DSIZE, FIFO write data.
- push_last, out, 1, marks the final beat of a burst.
- axi_arid, out, IDSIZE, ARID (= ID).
- axi_araddr, out, ASIZE, ARADDR.
- axi_arlen, out, LSIZE, ARLEN.
- axi_arsize, out, 3, ARSIZE.
- axi_arburst, out, 2, ARBURST (2'b01 INCR).
- axi_arlock, out, 1, ARLOCK (0).
- axi_arcache, out, 4, ARCACHE (4'b0011).
- axi_arprot, out, 3, ARPROT (0).
- axi_arqos, out, 4, ARQOS (0).
- axi_arvalid, out, 1, ARVALID.
- axi_arready, in, 1, ARREADY.
- axi_rid, in, IDSIZE, RID.
- axi_rdata, in, DSIZE, RDATA.
- axi_rresp, in, 2, RRESP.
- axi_rlast, in, 1, RLAST.
- axi_rvalid, in, 1, RVALID.
- axi_rready, out, 1, RREADY.

Behaviour:
- Reset: state IDLE; all outputs 0 except the constant AR fields; beat counter 0.
- Reset asserted mid-burst aborts immediately; no req_done is issued.
- State IDLE:
  - If read_req=1, capture req_addr/req_len into axi_araddr/axi_arlen.
  - Assert axi_arvalid the next cycle; go to ADDR.
  - Latency from read_req to ARVALID is 1 cycle.
- State ADDR:
  - Hold ARVALID and all AR fields stable until axi_arready=1.
  - On that cycle: drop ARVALID next cycle, pulse req_resp for 1 cycle, go to DATA.
- State DATA:
  - axi_rready = !fifo_almost_full (combinational from a registered state bit).
  - A beat is accepted on axi_rvalid && axi_rready.
  - On acceptance: push_data_en=1 and push_data=axi_rdata in the same cycle (registered output, 1-cycle latency; push_data_en is also registered).
  - On acceptance: beat counter +1; counter width is LSIZE.
  - push_last=1 on the beat where counter==axi_arlen.
  - After that beat, go to DONE; axi_rlast is not used for termination.
- State DONE: pulse req_done for 1 cycle, reset the counter, return to IDLE.
  - Minimum turnaround: 2 cycles from the last R beat to the next ARVALID.
- read_req outside IDLE is ignored; the requester waits for req_done.
- fifo_almost_full may toggle every cycle; RREADY follows it with no beat loss or duplication.
- Boundary cases:
  - req_len=0: single beat; push_last on the first beat.
  - req_len=2^LSIZE-1: counter reaches the max without wrap, then terminates.

Optional Feature:
- Macro: READ_RESP_CHECK_EN.
- When defined, adds output rd_err (1 bit, sticky, cleared only by reset). rd_err sets when any of the following occur on an accepted beat:
  - rresp!=0;
  - rid!=ID;
  - rlast mismatches the expected last beat (rlast early, or missing on the final beat).
- Data flow is unaffected by rd_err.
- When the macro is undefined, rd_err and its checking logic are absent, and RRESP/RID/RLAST are ignored.

Decomposition:
- Shared package axi_vdma_pkg holds:
  - state enum {IDLE, ADDR, DATA, DONE};
  - AXI constants BURST_INCR=2'b01, CACHE_DEF=4'b0011, RESP_OKAY=2'b00;
  - function clog2 for ARSIZE.
- No sub-module; the beat counter and FSM stay in one module.

Test Plan:
- read_req, addr=0x1000, len=7, ARREADY at cycle 3, continuous RVALID:
  - ARADDR=0x1000, ARLEN=7, ARSIZE=5, ARBURST=1;
  - 8 pushes, push_last on beat 8;
  - req_resp once, req_done once.
- len=0 with ARREADY held low for 10 cycles:
  - ARVALID and all AR fields stable for those 10 cycles;
  - one push with push_last=1; req_done 2 cycles later.
- len=15, fifo_almost_full toggles every other cycle, RVALID always high:
  - RREADY mirrors !almost_full;
  - exactly 16 pushes, in order, no duplicates.
- Second read_req during DATA:
  - ignored; only one AR issued until req_done.
- axi_resetn dropped at beat 3 of 8:
  - all outputs clear asynchronously; no req_done.
  - After release, a new request completes normally.
- With READ_RESP_CHECK_EN:
  - RRESP=2 on beat 2 → rd_err=1 and stays 1;
  - rlast on beat 4 of 8 → rd_err=1;
  - all 8 beats are still pushed.
